// File: rtl/neuron_mac_seq.sv
// Time-multiplexed neuron: one signed Q-format multiplier is reused over N_IN serial (a, w) beats.
// The products are accumulated onto a bias, then the sum is saturated and activated, and the result is returned over valid/ready.
module neuron_mac_seq #(
  parameter int WIDTH = 32,
  parameter int FBITS = 24,
  parameter int N_IN  = 8,
  parameter int ACC_W = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] bias,
  input  logic [1:0]       act_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] w_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             busy
);

  localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);

  localparam logic signed [WIDTH-1:0] Y_MAX     = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] Y_MIN     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_MAX   = ACC_W'(Y_MAX);
  localparam logic signed [ACC_W-1:0] ACC_MIN   = ACC_W'(Y_MIN);
  localparam logic signed [WIDTH-1:0] ONE_Q     = WIDTH'(1) << FBITS;
  localparam logic signed [WIDTH-1:0] NEG_ONE_Q = -ONE_Q;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_ACT,
    S_DONE
  } state_e;

  state_e                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [1:0]                mode_q, mode_d;
  logic signed [WIDTH-1:0]   y_q, y_d;
  logic                      out_valid_q, out_valid_d;

  logic signed [2*WIDTH-1:0] prod_full;
  logic signed [2*WIDTH-1:0] prod_sh;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   bias_ext;
  logic signed [WIDTH-1:0]   sat;
  logic signed [WIDTH-1:0]   act_val;

  // Full-precision product, floored back to Q format by the arithmetic shift.
  always_comb begin
    prod_full = (2*WIDTH)'($signed(a_in)) * (2*WIDTH)'($signed(w_in));
    prod_sh   = prod_full >>> FBITS;
    prod_ext  = ACC_W'(prod_sh);
    bias_ext  = ACC_W'($signed(bias));
  end

  always_comb begin
    if (acc_q > ACC_MAX) begin
      sat = Y_MAX;
    end else if (acc_q < ACC_MIN) begin
      sat = Y_MIN;
    end else begin
      sat = acc_q[WIDTH-1:0];
    end

    unique case (mode_q)
      2'd1:    act_val = (sat < 0) ? '0 : sat;
      2'd2:    act_val = (sat > ONE_Q) ? ONE_Q : ((sat < NEG_ONE_Q) ? NEG_ONE_Q : sat);
      default: act_val = sat;
    endcase
  end

  always_comb begin
    // NOTE: every next-state signal starts as a copy of its flop so no path through this block can infer a latch.
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;

    if (en) begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            acc_d   = bias_ext;
            mode_d  = act_mode;
            cnt_d   = '0;
            state_d = S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            acc_d = acc_q + prod_ext;
            if (cnt_q == CNT_LAST) begin
              cnt_d   = '0;
              state_d = S_ACT;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_ACT: begin
          y_d         = act_val;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
        S_DONE: begin
          // y deliberately keeps its value after the handshake completes.
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values, regardless of statement order.
    if (!rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = en && (state_q == S_ACCUM);
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq (N_IN=3, Q8.24), with a plain-arithmetic reference model.
// A negedge monitor compares every valid output cycle against the queue of expected results.
module tb_neuron_mac_seq;

  localparam int WIDTH = 32;
  localparam int FBITS = 24;
  localparam int N_IN  = 3;
  localparam longint LMAX = 64'sd2147483647;
  localparam longint LMIN = -64'sd2147483648;
  localparam longint LONE = 64'sd16777216;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        start;
  logic [31:0] bias;
  logic [1:0]  act_mode;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_in;
  logic [31:0] w_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        busy;

  int errors = 0;
  int checks = 0;
  bit mon_on = 1'b0;
  logic [31:0] exp_q[$];

  neuron_mac_seq #(.WIDTH(WIDTH), .FBITS(FBITS), .N_IN(N_IN), .ACC_W(2*WIDTH)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .bias(bias), .act_mode(act_mode),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .w_in(w_in),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact integer sum of floored products, then clamp and activation.
  function automatic logic [31:0] model(input logic [31:0] b, input logic [1:0] m,
                                        input logic [31:0] av[3], input logic [31:0] wv[3]);
    longint sum;
    longint s;
    sum = longint'($signed(b));
    for (int i = 0; i < 3; i++) begin
      sum += (longint'($signed(av[i])) * longint'($signed(wv[i]))) >>> FBITS;
    end
    s = (sum > LMAX) ? LMAX : ((sum < LMIN) ? LMIN : sum);
    if (m == 2'd1 && s < 0) s = 0;
    if (m == 2'd2) s = (s > LONE) ? LONE : ((s < -LONE) ? -LONE : s);
    return 32'(s);
  endfunction

  // Monitor: y must equal the pending expectation on every cycle out_valid is high.
  always @(negedge clk) begin
    if (mon_on) begin
      if (!en) check("in_ready_en0", {31'b0, in_ready}, 32'd0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {31'b0, out_valid}, 32'd0);
        end else begin
          check("mon_y", y, exp_q[0]);
          if (out_ready && en && rst) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_start(input logic [31:0] b, input logic [1:0] m);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("timeout_idle", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    bias = b; act_mode = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] a, input logic [31:0] w);
    int n = 0;
    a_in = a; w_in = w; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("timeout_beat", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_eval(input string nm, input logic [31:0] b, input logic [1:0] m,
                          input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                          input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                          input bit stall, input logic [31:0] lit);
    logic [31:0] av[3];
    logic [31:0] wv[3];
    logic [31:0] e;
    logic [31:0] got;
    int n;
    av = '{a0, a1, a2};
    wv = '{w0, w1, w2};
    e = model(b, m, av, wv);
    check({nm, "_model"}, e, lit);
    out_ready = !stall;
    do_start(b, m);
    exp_q.push_back(e);
    for (int i = 0; i < 3; i++) begin
      send_beat(av[i], wv[i]);
      if (stall && i == 0) begin
        a_in = av[1]; w_in = wv[1]; in_valid = 1'b1; en = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check({nm, "_busy_en0"}, {31'b0, busy}, 32'd1);
        end
        @(posedge clk); #1;
        en = 1'b1; in_valid = 1'b0;
      end
      if (stall && i < 2) begin
        @(posedge clk); #1;
      end
    end
    if (!stall) begin
      @(negedge clk);
      check({nm, "_lat_act"}, {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      check({nm, "_lat_valid"}, {31'b0, out_valid}, 32'd1);
    end
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check({nm, "_timeout_out"}, {31'b0, out_valid}, 32'd1);
    if (stall) begin
      for (int k = 0; k < 5; k++) begin
        @(posedge clk); #1;
        start = ~start;
        @(negedge clk);
        check({nm, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
      end
      @(posedge clk); #1;
      start = 1'b1; out_ready = 1'b1;
      @(negedge clk);
    end
    got = y;
    @(posedge clk); #1;
    start = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check({nm, "_y"}, got, lit);
    check({nm, "_idle"}, {30'b0, busy, out_valid}, 32'd0);
    check({nm, "_y_kept"}, y, lit);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en = 1'b1; start = 1'b0; bias = '0; act_mode = '0;
    in_valid = 1'b0; a_in = '0; w_in = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {28'b0, busy, out_valid, in_ready, 1'b0}, 32'd0);
    check("rst_y", y, 32'd0);
    rst = 1'b1;
    mon_on = 1'b1;

    run_eval("ident", 32'h00800000, 2'd0, 32'h01000000, 32'h02000000, 32'hFF000000,
             32'h00800000, 32'h00400000, 32'h01000000, 1'b0, 32'h00800000);
    run_eval("ident3", 32'h00800000, 2'd3, 32'h01000000, 32'h02000000, 32'hFF000000,
             32'h00800000, 32'h00400000, 32'h01000000, 1'b0, 32'h00800000);
    run_eval("relu_neg", 32'hFE000000, 2'd1, 32'h0, 32'h0, 32'h0,
             32'h01000000, 32'h01000000, 32'h01000000, 1'b0, 32'h00000000);
    run_eval("ident_neg", 32'hFE000000, 2'd0, 32'h0, 32'h0, 32'h0,
             32'h01000000, 32'h01000000, 32'h01000000, 1'b0, 32'hFE000000);
    run_eval("relu_pos", 32'h00000000, 2'd1, 32'h01000000, 32'h01000000, 32'h0,
             32'h00400000, 32'h00400000, 32'h0, 1'b0, 32'h00800000);
    run_eval("htanh_p3", 32'h03000000, 2'd2, 32'h0, 32'h0, 32'h0,
             32'h0, 32'h0, 32'h0, 1'b0, 32'h01000000);
    run_eval("htanh_m3", 32'hFD000000, 2'd2, 32'h0, 32'h0, 32'h0,
             32'h0, 32'h0, 32'h0, 1'b0, 32'hFF000000);
    run_eval("htanh_q", 32'h00000000, 2'd2, 32'h01000000, 32'h00800000, 32'h0,
             32'h00200000, 32'h00400000, 32'h0, 1'b0, 32'h00400000);
    run_eval("sat_pos", 32'h0, 2'd0, 32'h7F000000, 32'h7F000000, 32'h7F000000,
             32'h7F000000, 32'h7F000000, 32'h7F000000, 1'b0, 32'h7FFFFFFF);
    run_eval("sat_neg", 32'h0, 2'd0, 32'h81000000, 32'h81000000, 32'h81000000,
             32'h7F000000, 32'h7F000000, 32'h7F000000, 1'b0, 32'h80000000);
    run_eval("floor", 32'h0, 2'd0, 32'hFFFFFFFF, 32'h0, 32'h0,
             32'h00000001, 32'h0, 32'h0, 1'b0, 32'hFFFFFFFF);
    run_eval("stall", 32'h00800000, 2'd0, 32'h01000000, 32'h02000000, 32'hFF000000,
             32'h00800000, 32'h00400000, 32'h01000000, 1'b1, 32'h00800000);
    run_eval("post_stall", 32'hFE000000, 2'd0, 32'h0, 32'h0, 32'h0,
             32'h0, 32'h0, 32'h0, 1'b0, 32'hFE000000);

    // Abort a large partial sum with reset after two beats.
    out_ready = 1'b1;
    do_start(32'h00000000, 2'd0);
    send_beat(32'h7F000000, 32'h7F000000);
    send_beat(32'h7F000000, 32'h7F000000);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_ready", {31'b0, in_ready}, 32'd0);
    check("midrst_y", y, 32'd0);
    rst = 1'b1;
    out_ready = 1'b0;
    run_eval("after_rst", 32'h00800000, 2'd0, 32'h01000000, 32'h02000000, 32'hFF000000,
             32'h00800000, 32'h00400000, 32'h01000000, 1'b0, 32'h00800000);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/neuron_mac_seq.md
Name: neuron_mac_seq

Overview:
- Parametrised, time-multiplexed neuron: one signed Qm.FBITS multiplier, reused over N_IN serial (a, w) beats.
- Accumulates onto a bias in a wide accumulator, saturates to WIDTH and applies a selectable activation.
- Returns the result over a valid/ready handshake.
- Successor of the fixed 3-input pipelined neuron, for layers with arbitrary fan-in where area matters more than throughput.

Parameters:
- WIDTH, 32, data word width (signed two's complement).
- FBITS, 24, fractional bits of the Q format (1.0 = 1<<FBITS).
- N_IN, 8, number of (a, w) pairs per evaluation (>=1).
- ACC_W, 2*WIDTH, accumulator width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- en  in  1  global enable; 0 freezes all state.
- start  in  1  begin evaluation; sampled only in IDLE.
- bias  in  WIDTH  bias, captured on accepted start.
- act_mode  in  2  activation, captured on accepted start: 0 identity, 1 ReLU, 2 hard-tanh, 3 identity.
- in_valid  in  1  a_in/w_in beat valid.
- in_ready  out  1  block accepts a beat.
- a_in  in  WIDTH  activation input, Q format.
- w_in  in  WIDTH  weight input, Q format.
- out_valid  out  1  y valid.
- out_ready  in  1  consumer accepts y.
- y  out  WIDTH  neuron output, Q format.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=0 at an edge): state IDLE, acc=0, beat counter=0, y=0, out_valid=0, in_ready=0, busy=0.
  - Reset has priority over en and applies mid-operation; any partial sum is discarded.
- en=0: no register updates, in_ready forced 0, outputs hold their values.
- FSM IDLE -> ACCUM -> ACT -> DONE -> IDLE.
- IDLE:
  - start=1 & en=1: acc <= sign-extended bias, mode latched, counter <= 0, go to ACCUM.
  - start while not IDLE is ignored.
- ACCUM:
  - in_ready = en.
  - Beat accepted when in_valid & in_ready: product = a_in*w_in as full 2*WIDTH signed, arithmetic shift right by FBITS (floor), sign-extended to ACC_W; acc <= acc + product; counter++.
  - On the N_IN-th accepted beat the counter wraps to 0 and state goes to ACT.
  - Gaps in in_valid simply stall.
- ACT (one cycle):
  - sat = acc clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - mode 0/3: y <= sat.
  - mode 1: y <= (sat<0) ? 0 : sat.
  - mode 2: y <= clamp(sat, -(1<<FBITS), +(1<<FBITS)).
  - out_valid <= 1, go to DONE.
- DONE:
  - y and out_valid held stable until out_ready=1 & en=1.
  - On that edge: out_valid <= 0, go to IDLE. y keeps its last value.
  - start in the same cycle is ignored; the next start is accepted no earlier than the following cycle.
- Latency: last beat accepted at edge k -> out_valid=1 after edge k+1. Minimum evaluation is N_IN+2 cycles from start, plus a 1-cycle return to IDLE.
- The accumulator never wraps for ACC_W=2*WIDTH and N_IN <= 2^FBITS. Saturation happens only at ACT.

Test Plan:
- Identity, N_IN=3, FBITS=24:
  - Stimulus: bias=0x00800000, a=(0x01000000, 0x02000000, 0xFF000000), w=(0x00800000, 0x00400000, 0x01000000), back-to-back beats.
  - Response: y=0x00800000; out_valid exactly 2 cycles after the last beat edge.
- ReLU, N_IN=3:
  - Stimulus: bias=0xFE000000 (-2.0), all a=0.
  - Response: y=0x00000000.
  - Same run with mode 0: y=0xFE000000.
- Hard-tanh, N_IN=3, sums of +3.0 and -3.0:
  - Response: y=0x01000000 and y=0xFF000000 respectively.
  - Sum 0.25 passes through as 0x00400000.
- Saturation, N_IN=3, mode 0:
  - Stimulus: a=w=0x7F000000 on all beats.
  - Response: y=0x7FFFFFFF. With a negated: y=0x80000000.
- Handshake and stall:
  - Stimulus: in_valid toggled 1-0-1-0, en dropped for 3 cycles mid-ACCUM, out_ready held low 5 cycles.
  - Response: result equals the no-stall run; y stable and out_valid=1 throughout; start pulses during DONE ignored; in_ready=0 whenever en=0.
- Reset mid-operation:
  - Stimulus: rst=0 for 1 cycle after 2 of 3 beats.
  - Response: busy=0, y=0, out_valid=0. The next full evaluation gives a result unaffected by the earlier partial sum.
